// File: rtl/neuron_pkg.sv
// Shared constants and FSM state type for the back-contribution accumulator.
package neuron_pkg;

    localparam int LANES  = 32;
    localparam int WORD_W = 32;
    localparam int ACC_W  = 64;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

endpackage

// File: rtl/bc_acc_lane.sv
// One 64-bit lane accumulator: load overwrites, add accumulates; both sign-extend the 32-bit input.
module bc_acc_lane
    import neuron_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_add,
    input  logic [WORD_W-1:0] i_lane,
    output logic [ACC_W-1:0]  o_acc
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_lane_sx;

    assign w_lane_sx = {{(ACC_W-WORD_W){i_lane[WORD_W-1]}}, i_lane};

    // Accumulator register; load takes priority so a new batch never sees stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_lane_sx;
        end else if (i_add) begin
            r_acc <= r_acc + w_lane_sx;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/bc_accumulator.sv
// Sums N_DOWN back-contribution vectors lane-wise, then drains the 32 sums one per output transfer.
module bc_accumulator
    import neuron_pkg::*;
#(
    parameter int N_DOWN = 32
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0][WORD_W-1:0] ac_bc,
    input  logic                         ac_bc_valid,
    output logic                         ac_bc_ready,
    output logic [ACC_W-1:0]             ac_bp,
    output logic [IDX_W-1:0]             ac_bp_idx,
    output logic                         ac_bp_valid,
    input  logic                         ac_bp_ready,
    output logic                         ac_busy
);

    localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N_DOWN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    acc_state_t       r_state;
    acc_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_load;
    logic             w_add;
    logic [ACC_W-1:0] w_acc [LANES];

    // State, vector count and drain index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state logic, handshakes and accumulator enables.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_load       = 1'b0;
        w_add        = 1'b0;
        ac_bc_ready  = 1'b0;
        ac_bp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                ac_bc_ready = 1'b1;
                if (ac_bc_valid) begin
                    w_load       = 1'b1;
                    w_cnt_next   = CNT_W'(1);
                    w_state_next = (N_DOWN == 1) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                ac_bc_ready = 1'b1;
                if (ac_bc_valid) begin
                    w_add      = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_cnt_next == N_LAST) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                ac_bp_valid = 1'b1;
                if (ac_bp_ready) begin
                    if (r_idx == IDX_LAST) begin
                        w_idx_next   = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            bc_acc_lane u_lane (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_load),
                .i_add  (w_add),
                .i_lane (ac_bc[gi]),
                .o_acc  (w_acc[gi])
            );
        end
    endgenerate

    // Output mux is forced to zero whenever no result is being offered.
    assign ac_bp     = ac_bp_valid ? w_acc[r_idx] : '0;
    assign ac_bp_idx = r_idx;
    assign ac_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_bc_accumulator.sv
// Bench for bc_accumulator: three instances with N_DOWN = 1, 2, 3, table rows plus hand sequences.
module tb_bc_accumulator;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0][31:0]   bc        [3];
    logic                bc_valid  [3];
    logic                bc_ready  [3];
    logic [63:0]         bp        [3];
    logic [4:0]          bp_idx    [3];
    logic                bp_valid  [3];
    logic                bp_ready  [3];
    logic                busy      [3];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] val;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          inst;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] f2;
        logic [63:0] exp;
    } row_t;
    row_t tbl [7];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            bc_accumulator #(.N_DOWN(gi + 1)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .ac_bc       (bc[gi]),
                .ac_bc_valid (bc_valid[gi]),
                .ac_bc_ready (bc_ready[gi]),
                .ac_bp       (bp[gi]),
                .ac_bp_idx   (bp_idx[gi]),
                .ac_bp_valid (bp_valid[gi]),
                .ac_bp_ready (bp_ready[gi]),
                .ac_busy     (busy[gi])
            );
        end
    endgenerate

    function automatic logic [31:0][31:0] fill(input logic [31:0] x);
        logic [31:0][31:0] v;
        for (int i = 0; i < 32; i++) v[i] = x;
        return v;
    endfunction

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input int s);
        chk("idle_bc_ready", 64'(bc_ready[s]), 64'd1);
        chk("idle_bp_valid", 64'(bp_valid[s]), 64'd0);
        chk("idle_bp",       bp[s],            64'd0);
        chk("idle_bp_idx",   64'(bp_idx[s]),   64'd0);
        chk("idle_busy",     64'(busy[s]),     64'd0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push_vec(input int s, input logic [31:0][31:0] v);
        int guard = 0;
        while (bc_ready[s] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_err++;
            $display("FAIL push_timeout: inst %0d bc_ready stuck low", s);
        end
        bc[s]       = v;
        bc_valid[s] = 1'b1;
        @(negedge clk);
        bc_valid[s] = 1'b0;
        bc[s]       = '0;
        $display("inst%0d in  lane0=%h", s, v[0]);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles at idx 4 with ignored input pulses
    task automatic drain(input int s, input int mode);
        int          got = 0;
        int          cyc = 0;
        int          stall = 0;
        logic        stalling;
        logic [63:0] hold_bp = '0;
        logic [4:0]  hold_idx = '0;
        exp_t        e;
        chk("first_valid", 64'(bp_valid[s]), 64'd1);
        chk("first_idx",   64'(bp_idx[s]),   64'd0);
        while (got < 32 && cyc < 400) begin
            if (mode == 0) chk("consec_valid", 64'(bp_valid[s]), 64'd1);
            if (!bp_valid[s]) chk("bp_zero", bp[s], 64'd0);
            else              chk("drain_bc_ready", 64'(bc_ready[s]), 64'd0);
            stalling = (mode == 2) && (bp_idx[s] == 5'd4) && (stall < 5);
            if (stalling) begin
                if (stall > 0) begin
                    chk("hold_bp",  bp[s],             hold_bp);
                    chk("hold_idx", 64'(bp_idx[s]),    64'(hold_idx));
                end
                hold_bp     = bp[s];
                hold_idx    = bp_idx[s];
                stall++;
                bp_ready[s] = 1'b0;
                bc_valid[s] = 1'b1;
                bc[s]       = fill(32'h5555_5555);
            end else begin
                bc_valid[s] = 1'b0;
                bc[s]       = '0;
                bp_ready[s] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bp_valid[s] && bp_ready[s]) begin
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: inst %0d idx %0d bp %h", s, bp_idx[s], bp[s]);
                end else begin
                    e = sbq.pop_front();
                    chk("out_idx", 64'(bp_idx[s]), 64'(e.idx));
                    chk("out_val", bp[s], e.val);
                end
                $display("inst%0d out idx=%0d bp=%h", s, bp_idx[s], bp[s]);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 400) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d of 32 outputs", got);
        end
        bp_ready[s] = 1'b0;
        bc_valid[s] = 1'b0;
        chk_idle(s);
    endtask

    initial begin
        logic [31:0][31:0] va;
        logic [31:0][31:0] vb;
        logic [31:0]       f;
        int                s;

        tbl[0] = '{1, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0, 64'd2};
        tbl[1] = '{0, 32'h0000_0001, 32'h0,         32'h0, 64'd1};
        tbl[2] = '{0, 32'h0000_000A, 32'h0,         32'h0, 64'd10};
        tbl[3] = '{1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 64'h0000_0000_FFFF_FFFE};
        tbl[4] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h0, 64'hFFFF_FFFF_0000_0000};
        tbl[5] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD};
        tbl[6] = '{2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h0000_0001_7FFF_FFFD};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bc[k] = '0; bc_valid[k] = 1'b0; bp_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_idle(k);
        rst = 1'b0;
        @(negedge clk);

        // Uniform-lane table rows, always-ready drain
        for (int r = 0; r < 7; r++) begin
            s = tbl[r].inst;
            for (int k = 0; k <= s; k++) begin
                f = (k == 0) ? tbl[r].f0 : (k == 1) ? tbl[r].f1 : tbl[r].f2;
                push_vec(s, fill(f));
            end
            for (int i = 0; i < 32; i++) sbq.push_back('{5'(i), tbl[r].exp});
            drain(s, 0);
        end

        // Mixed lanes with overflow-prone lanes 7 and 3, stalled at idx 4
        for (int i = 0; i < 32; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        va[7] = 32'h7FFF_FFFF; vb[7] = 32'h7FFF_FFFF;
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000;
        push_vec(1, va);
        push_vec(1, vb);
        for (int i = 0; i < 32; i++) sbq.push_back('{5'(i), sx(va[i]) + sx(vb[i])});
        drain(1, 2);

        // Reset mid-ACCUM with a simultaneous input vector, then a clean batch
        push_vec(2, fill(32'd7));
        push_vec(2, fill(32'd7));
        rst = 1'b1;
        bc[2] = fill(32'd9);
        bc_valid[2] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bc_valid[2] = 1'b0;
        bc[2] = '0;
        chk_idle(2);
        for (int k = 0; k < 3; k++) push_vec(2, fill(32'd1));
        for (int i = 0; i < 32; i++) sbq.push_back('{5'(i), 64'd3});
        drain(2, 0);

        // Reset mid-DRAIN
        push_vec(1, fill(32'd4));
        push_vec(1, fill(32'd4));
        chk("md_valid", 64'(bp_valid[1]), 64'd1);
        bp_ready[1] = 1'b1;
        @(negedge clk);
        chk("md_idx", 64'(bp_idx[1]), 64'd1);
        bp_ready[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(1);

        // Random ready pattern, N_DOWN = 1, random lanes
        for (int i = 0; i < 32; i++) va[i] = $urandom;
        push_vec(0, va);
        for (int i = 0; i < 32; i++) sbq.push_back('{5'(i), sx(va[i])});
        drain(0, 1);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bc_accumulator.md
BC_ACCUMULATOR -- requirements
Module: bc_accumulator

Interface
REQ-001 SHALL have parameter N_DOWN, default 32, the number of downstream back-contribution vectors summed per error result (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ac_bc, input, [31:0][31:0], one back-contribution vector (32 signed lanes) from a downstream backPropper.
REQ-005 SHALL have port ac_bc_valid, input, 1, ac_bc holds a vector.
REQ-006 SHALL have port ac_bc_ready, output, 1, the block can accept a vector this cycle.
REQ-007 SHALL have port ac_bp, output, 64, the summed signed error for one upstream neuron, i.e. that neuron's bp_bp.
REQ-008 SHALL have port ac_bp_idx, output, 5, lane or neuron index of ac_bp.
REQ-009 SHALL have port ac_bp_valid, output, 1, ac_bp and ac_bp_idx are valid.
REQ-010 SHALL have port ac_bp_ready, input, 1, the consumer accepts ac_bp.
REQ-011 SHALL have port ac_busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, ACCUM and DRAIN.
REQ-013 An input transfer SHALL occur when ac_bc_valid and ac_bc_ready are both high. An output transfer SHALL occur when ac_bp_valid and ac_bp_ready are both high.
REQ-014 ac_bc_ready SHALL be 1 in IDLE and ACCUM and 0 in DRAIN, so input and output transfers never occur in the same cycle.
REQ-015 IDLE transfer: each of the 32 64-bit accumulators SHALL load the sign-extended lane, with no add to stale contents. The count SHALL be set to 1. Next state SHALL be DRAIN if N_DOWN==1, otherwise ACCUM.
REQ-016 ACCUM transfer: each accumulator SHALL add its sign-extended lane, and the count SHALL increment. When the count reaches N_DOWN, next state SHALL be DRAIN.
REQ-017 Accumulator arithmetic SHALL be two's complement and wrap modulo 2^64, with no saturation and no overflow flag.
REQ-018 Latency: when the final input transfers at cycle t, ac_bp_valid SHALL be 1 at t+1 with ac_bp_idx=0.
REQ-019 In DRAIN, ac_bp SHALL equal accumulator[ac_bp_idx]. Each output transfer SHALL increment ac_bp_idx.
REQ-020 When the output transfer with idx=31 occurs, next state SHALL be IDLE, ac_bp_valid SHALL be 0, and ac_bp_idx SHALL be 0.
REQ-021 While ac_bp_valid=1 and ac_bp_ready=0, ac_bp and ac_bp_idx SHALL hold stable.
REQ-022 ac_bp_valid SHALL be 0 outside DRAIN, and ac_bp SHALL be 0 when ac_bp_valid=0.
REQ-023 The block SHALL accept a new vector in the first IDLE cycle after the drain completes, with no bubble beyond that state change.
REQ-024 ac_bc_valid with ac_bc_ready=0 SHALL have no effect; the input is not captured.

Reset
REQ-025 rst=1 SHALL force IDLE and clear the count, ac_bp_idx and all accumulators to 0, from any state, including mid-ACCUM and mid-DRAIN.
REQ-026 Reset output values SHALL be: ac_bc_ready=1, ac_bp_valid=0, ac_bp=0, ac_bp_idx=0, ac_busy=0.
REQ-027 Reset SHALL take priority over a simultaneous transfer, and the input vector presented in that cycle SHALL be discarded.

Structure
REQ-028 The shared package neuron_pkg SHALL hold the lane count (32), WORD_W (32), ACC_W (64) and the state enum for IDLE, ACCUM and DRAIN.
REQ-029 The block SHALL use one sub-module, bc_acc_lane: a single 64-bit accumulator with load and add enables, instantiated 32 times through a generate loop.
REQ-030 The index-to-output mux and the FSM SHALL reside in bc_accumulator.

Verification
REQ-031 With N_DOWN=2, send vectors with all lanes 5, then all lanes -3, with ac_bp_ready=1 -> 32 outputs of value 2, idx 0..31 on consecutive cycles, the first at t+1.
REQ-032 With N_DOWN=2, lane 7 = 0x7FFFFFFF in both vectors -> ac_bp at idx 7 equals 0x00000000FFFFFFFE; lane 3 = 0x80000000 twice -> 0xFFFFFFFF00000000.
REQ-033 In DRAIN, hold ac_bp_ready=0 for 5 cycles at idx 4 -> ac_bp and ac_bp_idx stable, ac_bc_ready=0, and ac_bc_valid pulses ignored.
REQ-034 With N_DOWN=3, assert rst after 2 input transfers, then send 3 vectors of all lanes 1 -> outputs equal 3, with no residue from before reset.
REQ-035 Run two back-to-back batches (lanes 1 then lanes 10, N_DOWN=1) -> the second batch outputs 10, proving the IDLE load clears the accumulators.
REQ-036 With N_DOWN=1 and a random per-cycle ac_bp_ready pattern -> exactly 32 transfers in index order, each equal to its input lane sign-extended.
